// File: rtl/measure_block_mo.sv
// Passive Avalon-MM snooper: tracks in-flight read bursts in a circular FIFO and
// collects first-word latency statistics, throughput counters and error flags.
module measure_block_mo #(
  parameter int    AMM_BURST_W     = 11,
  parameter int    DATA_B_W        = 16,
  parameter int    MAX_OUTSTANDING = 4,
  parameter int    DELAY_W         = 16,
  parameter string ADDR_TYPE       = "BYTE"
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic                   waitrequest_i,
  input  logic                   readdatavalid_i,
  input  logic [AMM_BURST_W-1:0] burstcount_i,
  input  logic [DATA_B_W-1:0]    byteenable_i,
  input  logic                   test_start_i,
  output logic                   meas_busy_o,
  output logic                   err_ovf_o,
  output logic                   err_orphan_o,
  output logic [31:0]            wr_ticks_o,
  output logic [31:0]            wr_units_o,
  output logic [31:0]            rd_ticks_o,
  output logic [31:0]            rd_words_o,
  output logic [31:0]            rd_req_o,
  output logic [DELAY_W-1:0]     lat_min_o,
  output logic [DELAY_W-1:0]     lat_max_o,
  output logic [31:0]            lat_sum_o
);
  localparam int PTR_W     = $clog2(MAX_OUTSTANDING);
  localparam int OCC_W     = PTR_W + 1;
  localparam int PC_W      = $clog2(DATA_B_W + 1);
  localparam bit WORD_MODE = (ADDR_TYPE == "WORD");

  logic [PTR_W-1:0]       ld_ptr_q, act_ptr_q;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   err_ovf_q, err_orphan_q, freeze_q;
  logic                   first_vld_q, wr_pend_q;
  logic [DELAY_W-1:0]     first_lat_q, lat_min_q, lat_max_q;
  logic [PC_W-1:0]        wr_cnt_q, be_cnt;
  logic [31:0]            wr_ticks_q, wr_units_q, rd_ticks_q, rd_words_q, rd_req_q, lat_sum_q;

  logic [AMM_BURST_W-1:0] slot_words [MAX_OUTSTANDING];
  logic                   slot_seen  [MAX_OUTSTANDING];
  logic [DELAY_W-1:0]     slot_lat   [MAX_OUTSTANDING];

  logic                   rd_acc, wr_acc, trk_empty, trk_full;
  logic                   beat, orphan, pop, load, ovf, first_beat;
  logic [AMM_BURST_W-1:0] act_words, load_words;
  logic [DELAY_W-1:0]     act_lat, first_lat;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign rd_acc     = read_i & ~waitrequest_i;
  assign wr_acc     = write_i & ~waitrequest_i;
  assign trk_empty  = (occ_q == '0);
  assign trk_full   = (occ_q == OCC_W'(MAX_OUTSTANDING));
  assign beat       = readdatavalid_i & ~trk_empty;
  assign orphan     = readdatavalid_i & trk_empty;
  assign act_words  = slot_words[act_ptr_q];
  assign act_lat    = slot_lat[act_ptr_q];
  assign pop        = beat & (act_words <= AMM_BURST_W'(1));
  // A full tracker can still take a command when the oldest slot drains this cycle.
  assign load       = rd_acc & (~trk_full | pop);
  assign ovf        = rd_acc & trk_full & ~pop;
  assign first_beat = beat & ~slot_seen[act_ptr_q];
  assign first_lat  = (act_lat == '1) ? act_lat : act_lat + DELAY_W'(1);
  assign load_words = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;

  always_comb begin
    occ_d = occ_q;
    if (load && !pop)
      occ_d = occ_q + OCC_W'(1);
    else if (pop && !load)
      occ_d = occ_q - OCC_W'(1);
  end

  always_comb begin
    be_cnt = '0;
    for (int i = 0; i < DATA_B_W; i++)
      be_cnt = be_cnt + PC_W'(byteenable_i[i]);
  end

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
    logic [AMM_BURST_W-1:0] words_q;
    logic                   seen_q;
    logic [DELAY_W-1:0]     lat_q;
    logic [PTR_W-1:0]       rel;
    logic                   occupied, load_here, beat_here;

    assign rel       = PTR_W'(gi) - act_ptr_q;
    assign occupied  = ({1'b0, rel} < occ_q);
    assign load_here = load && (ld_ptr_q == PTR_W'(gi));
    assign beat_here = beat && (act_ptr_q == PTR_W'(gi));

    // Loading wins over the drain of the same slot when a full tracker wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        words_q <= '0;
        seen_q  <= 1'b0;
        lat_q   <= '0;
      end else if (load_here) begin
        words_q <= load_words;
        seen_q  <= 1'b0;
        lat_q   <= '0;
      end else if (occupied) begin
        if (beat_here) begin
          words_q <= words_q - AMM_BURST_W'(1);
          seen_q  <= 1'b1;
        end
        if (!seen_q && lat_q != '1)
          lat_q <= lat_q + DELAY_W'(1);
      end
    end

    assign slot_words[gi] = words_q;
    assign slot_seen[gi]  = seen_q;
    assign slot_lat[gi]   = lat_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_ptr_q     <= '0;
      act_ptr_q    <= '0;
      occ_q        <= '0;
      err_ovf_q    <= 1'b0;
      err_orphan_q <= 1'b0;
      freeze_q     <= 1'b0;
      first_vld_q  <= 1'b0;
      first_lat_q  <= '0;
      wr_pend_q    <= 1'b0;
      wr_cnt_q     <= '0;
      wr_ticks_q   <= '0;
      wr_units_q   <= '0;
      rd_ticks_q   <= '0;
      rd_words_q   <= '0;
      rd_req_q     <= '0;
      lat_min_q    <= '1;
      lat_max_q    <= '0;
      lat_sum_q    <= '0;
    end else begin
      ld_ptr_q    <= ld_ptr_q + PTR_W'(load);
      act_ptr_q   <= act_ptr_q + PTR_W'(pop);
      occ_q       <= occ_d;
      first_lat_q <= first_lat;
      wr_cnt_q    <= be_cnt;
      if (test_start_i) begin
        err_ovf_q    <= 1'b0;
        err_orphan_q <= 1'b0;
        freeze_q     <= 1'b0;
        first_vld_q  <= 1'b0;
        wr_pend_q    <= 1'b0;
        wr_ticks_q   <= '0;
        wr_units_q   <= '0;
        rd_ticks_q   <= '0;
        rd_words_q   <= '0;
        rd_req_q     <= '0;
        lat_min_q    <= '1;
        lat_max_q    <= '0;
        lat_sum_q    <= '0;
      end else begin
        first_vld_q <= first_beat;
        wr_pend_q   <= wr_acc && !WORD_MODE;
        if (write_i)   wr_ticks_q <= sat_add(wr_ticks_q, 32'd1);
        if (WORD_MODE) begin
          if (wr_acc)  wr_units_q <= sat_add(wr_units_q, 32'd1);
        end else if (wr_pend_q) begin
          wr_units_q <= sat_add(wr_units_q, 32'(wr_cnt_q));
        end
        if (!trk_empty)      rd_ticks_q <= sat_add(rd_ticks_q, 32'd1);
        if (readdatavalid_i) rd_words_q <= sat_add(rd_words_q, 32'd1);
        if (rd_acc)          rd_req_q   <= sat_add(rd_req_q, 32'd1);
        if (ovf) begin
          err_ovf_q <= 1'b1;
          freeze_q  <= 1'b1;
        end
        if (orphan) begin
          err_orphan_q <= 1'b1;
          freeze_q     <= 1'b1;
        end
        if (first_vld_q && !freeze_q) begin
          if (first_lat_q < lat_min_q) lat_min_q <= first_lat_q;
          if (first_lat_q > lat_max_q) lat_max_q <= first_lat_q;
          lat_sum_q <= sat_add(lat_sum_q, 32'(first_lat_q));
        end
      end
    end
  end

  assign meas_busy_o  = !trk_empty || wr_pend_q;
  assign err_ovf_o    = err_ovf_q;
  assign err_orphan_o = err_orphan_q;
  assign wr_ticks_o   = wr_ticks_q;
  assign wr_units_o   = wr_units_q;
  assign rd_ticks_o   = rd_ticks_q;
  assign rd_words_o   = rd_words_q;
  assign rd_req_o     = rd_req_q;
  assign lat_min_o    = lat_min_q;
  assign lat_max_o    = lat_max_q;
  assign lat_sum_o    = lat_sum_q;
endmodule

// File: tb/tb_measure_block_mo.sv
// Directed bench for measure_block_mo: a default (16-bit latency, BYTE) instance and a
// 4-bit latency WORD-mode instance share one stimulus stream.
module tb_measure_block_mo;
  logic        clk = 1'b0;
  logic        rst, read, write, waitreq, rdv, tstart;
  logic [10:0] burst;
  logic [15:0] be;

  logic        busy, ovf, orph;
  logic [31:0] wr_ticks, wr_units, rd_ticks, rd_words, rd_req, lat_sum;
  logic [15:0] lat_min, lat_max;

  logic        q_busy, q_ovf, q_orph;
  logic [31:0] q_wr_ticks, q_wr_units, q_rd_ticks, q_rd_words, q_rd_req, q_lat_sum;
  logic [3:0]  q_lat_min, q_lat_max;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  measure_block_mo dut (
    .clk_i(clk), .rst_i(rst), .read_i(read), .write_i(write), .waitrequest_i(waitreq),
    .readdatavalid_i(rdv), .burstcount_i(burst), .byteenable_i(be), .test_start_i(tstart),
    .meas_busy_o(busy), .err_ovf_o(ovf), .err_orphan_o(orph),
    .wr_ticks_o(wr_ticks), .wr_units_o(wr_units), .rd_ticks_o(rd_ticks),
    .rd_words_o(rd_words), .rd_req_o(rd_req),
    .lat_min_o(lat_min), .lat_max_o(lat_max), .lat_sum_o(lat_sum)
  );

  measure_block_mo #(.DELAY_W(4), .ADDR_TYPE("WORD")) dut4 (
    .clk_i(clk), .rst_i(rst), .read_i(read), .write_i(write), .waitrequest_i(waitreq),
    .readdatavalid_i(rdv), .burstcount_i(burst), .byteenable_i(be), .test_start_i(tstart),
    .meas_busy_o(q_busy), .err_ovf_o(q_ovf), .err_orphan_o(q_orph),
    .wr_ticks_o(q_wr_ticks), .wr_units_o(q_wr_units), .rd_ticks_o(q_rd_ticks),
    .rd_words_o(q_rd_words), .rd_req_o(q_rd_req),
    .lat_min_o(q_lat_min), .lat_max_o(q_lat_max), .lat_sum_o(q_lat_sum)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read = 0; write = 0; waitreq = 0; rdv = 0; tstart = 0; burst = '0; be = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %0h want 0", busy); n_err++; end n_cmp++;
    if (ovf !== 1'b0) begin $display("FAIL rst_ovf: got %0h want 0", ovf); n_err++; end n_cmp++;
    if (orph !== 1'b0) begin $display("FAIL rst_orphan: got %0h want 0", orph); n_err++; end n_cmp++;
    if (wr_ticks !== 32'd0) begin $display("FAIL rst_wr_ticks: got %0h want 0", wr_ticks); n_err++; end n_cmp++;
    if (wr_units !== 32'd0) begin $display("FAIL rst_wr_units: got %0h want 0", wr_units); n_err++; end n_cmp++;
    if (rd_ticks !== 32'd0) begin $display("FAIL rst_rd_ticks: got %0h want 0", rd_ticks); n_err++; end n_cmp++;
    if (rd_words !== 32'd0) begin $display("FAIL rst_rd_words: got %0h want 0", rd_words); n_err++; end n_cmp++;
    if (rd_req !== 32'd0) begin $display("FAIL rst_rd_req: got %0h want 0", rd_req); n_err++; end n_cmp++;
    if (lat_min !== 16'hFFFF) begin $display("FAIL rst_lat_min: got %0h want ffff", lat_min); n_err++; end n_cmp++;
    if (lat_max !== 16'd0) begin $display("FAIL rst_lat_max: got %0h want 0", lat_max); n_err++; end n_cmp++;
    if (lat_sum !== 32'd0) begin $display("FAIL rst_lat_sum: got %0h want 0", lat_sum); n_err++; end n_cmp++;
    if (q_lat_min !== 4'hF) begin $display("FAIL rst_lat_min4: got %0h want f", q_lat_min); n_err++; end n_cmp++;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    do_reset();
    read = 1; burst = 11'd4;
    cyc();
    read = 0; burst = '0;
    repeat (4) cyc();
    if (busy !== 1'b1) begin $display("FAIL single_busy_mid: got %0h want 1", busy); n_err++; end n_cmp++;
    rdv = 1;
    repeat (4) cyc();
    rdv = 0;
    if (busy !== 1'b0) begin $display("FAIL single_busy_end: got %0h want 0", busy); n_err++; end n_cmp++;
    cyc();
    if (lat_min !== 16'd5) begin $display("FAIL single_lat_min: got %0d want 5", lat_min); n_err++; end n_cmp++;
    if (lat_max !== 16'd5) begin $display("FAIL single_lat_max: got %0d want 5", lat_max); n_err++; end n_cmp++;
    if (lat_sum !== 32'd5) begin $display("FAIL single_lat_sum: got %0d want 5", lat_sum); n_err++; end n_cmp++;
    if (rd_words !== 32'd4) begin $display("FAIL single_rd_words: got %0d want 4", rd_words); n_err++; end n_cmp++;
    if (rd_req !== 32'd1) begin $display("FAIL single_rd_req: got %0d want 1", rd_req); n_err++; end n_cmp++;
    if (rd_ticks !== 32'd8) begin $display("FAIL single_rd_ticks: got %0d want 8", rd_ticks); n_err++; end n_cmp++;
    $display("test_single_read done: lat=%0d words=%0d", lat_max, rd_words);
  endtask

  // Five bursts; the fifth is accepted on the very edge the oldest burst drains.
  // First-data edges 3, 8, 10, 13, 15 give latencies 3, 7, 8, 10, 11.
  task automatic test_back_to_back();
    logic [15:0] rdv_mask;
    rdv_mask = 16'hEF18;
    do_reset();
    for (int e = 0; e < 16; e++) begin
      read  = (e <= 4);
      burst = (e == 4) ? 11'd1 : 11'd2;
      rdv   = rdv_mask[e];
      cyc();
      if (e == 4 && ovf !== 1'b0) begin $display("FAIL b2b_ovf_on_pop: got %0h want 0", ovf); n_err++; end
      if (e == 4) n_cmp++;
    end
    idle();
    cyc();
    if (lat_min !== 16'd3) begin $display("FAIL b2b_lat_min: got %0d want 3", lat_min); n_err++; end n_cmp++;
    if (lat_max !== 16'd11) begin $display("FAIL b2b_lat_max: got %0d want 11", lat_max); n_err++; end n_cmp++;
    if (lat_sum !== 32'd39) begin $display("FAIL b2b_lat_sum: got %0d want 39", lat_sum); n_err++; end n_cmp++;
    if (rd_req !== 32'd5) begin $display("FAIL b2b_rd_req: got %0d want 5", rd_req); n_err++; end n_cmp++;
    if (rd_words !== 32'd9) begin $display("FAIL b2b_rd_words: got %0d want 9", rd_words); n_err++; end n_cmp++;
    if (rd_ticks !== 32'd15) begin $display("FAIL b2b_rd_ticks: got %0d want 15", rd_ticks); n_err++; end n_cmp++;
    if ({ovf, orph} !== 2'b00) begin $display("FAIL b2b_errors: got %b want 00", {ovf, orph}); n_err++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL b2b_busy: got %0h want 0", busy); n_err++; end n_cmp++;
    $display("test_back_to_back done: min=%0d max=%0d sum=%0d", lat_min, lat_max, lat_sum);
  endtask

  task automatic test_overflow();
    do_reset();
    read = 1; burst = 11'd1;
    repeat (4) cyc();
    if (ovf !== 1'b0) begin $display("FAIL ovf_at_full: got %0h want 0", ovf); n_err++; end n_cmp++;
    cyc();
    read = 0;
    if (ovf !== 1'b1) begin $display("FAIL ovf_set: got %0h want 1", ovf); n_err++; end n_cmp++;
    if (rd_req !== 32'd5) begin $display("FAIL ovf_rd_req: got %0d want 5", rd_req); n_err++; end n_cmp++;
    cyc();
    rdv = 1;
    cyc();
    rdv = 0;
    cyc();
    cyc();
    if (lat_min !== 16'hFFFF) begin $display("FAIL ovf_frozen_min: got %0h want ffff", lat_min); n_err++; end n_cmp++;
    if (lat_sum !== 32'd0) begin $display("FAIL ovf_frozen_sum: got %0d want 0", lat_sum); n_err++; end n_cmp++;
    if (ovf !== 1'b1) begin $display("FAIL ovf_sticky: got %0h want 1", ovf); n_err++; end n_cmp++;
    tstart = 1;
    cyc();
    tstart = 0;
    if (ovf !== 1'b0) begin $display("FAIL ovf_cleared: got %0h want 0", ovf); n_err++; end n_cmp++;
    if (rd_req !== 32'd0) begin $display("FAIL ovf_req_cleared: got %0d want 0", rd_req); n_err++; end n_cmp++;
    if (lat_min !== 16'hFFFF) begin $display("FAIL ovf_min_cleared: got %0h want ffff", lat_min); n_err++; end n_cmp++;
    if (busy !== 1'b1) begin $display("FAIL ovf_tracker_kept: got %0h want 1", busy); n_err++; end n_cmp++;
    // Burst accepted on edge 1, first data on edge 10.
    rdv = 1;
    cyc();
    rdv = 0;
    cyc();
    if (lat_min !== 16'd9) begin $display("FAIL post_start_min: got %0d want 9", lat_min); n_err++; end n_cmp++;
    if (lat_sum !== 32'd9) begin $display("FAIL post_start_sum: got %0d want 9", lat_sum); n_err++; end n_cmp++;
    if (rd_words !== 32'd1) begin $display("FAIL post_start_words: got %0d want 1", rd_words); n_err++; end n_cmp++;
    $display("test_overflow done");
  endtask

  task automatic test_orphan();
    do_reset();
    rdv = 1;
    cyc();
    rdv = 0;
    if (orph !== 1'b1) begin $display("FAIL orphan_set: got %0h want 1", orph); n_err++; end n_cmp++;
    if (rd_words !== 32'd1) begin $display("FAIL orphan_words: got %0d want 1", rd_words); n_err++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL orphan_busy: got %0h want 0", busy); n_err++; end n_cmp++;
    read = 1; burst = 11'd1;
    cyc();
    read = 0; rdv = 1;
    cyc();
    rdv = 0;
    cyc();
    if (lat_min !== 16'hFFFF) begin $display("FAIL orphan_frozen_min: got %0h want ffff", lat_min); n_err++; end n_cmp++;
    if (lat_sum !== 32'd0) begin $display("FAIL orphan_frozen_sum: got %0d want 0", lat_sum); n_err++; end n_cmp++;
    if (rd_words !== 32'd2) begin $display("FAIL orphan_words2: got %0d want 2", rd_words); n_err++; end n_cmp++;
    $display("test_orphan done");
  endtask

  task automatic test_writes();
    do_reset();
    write = 1; be = 16'hFFFF;
    cyc();
    if (wr_units !== 32'd0) begin $display("FAIL wr_byte_delay: got %0d want 0", wr_units); n_err++; end n_cmp++;
    if (busy !== 1'b1) begin $display("FAIL wr_busy: got %0h want 1", busy); n_err++; end n_cmp++;
    if (q_wr_units !== 32'd1) begin $display("FAIL wr_word_same_edge: got %0d want 1", q_wr_units); n_err++; end n_cmp++;
    be = 16'h00FF; waitreq = 1;
    cyc();
    waitreq = 0;
    cyc();
    be = 16'h0001;
    cyc();
    write = 0; be = '0;
    if (wr_units !== 32'd24) begin $display("FAIL wr_units_mid: got %0d want 24", wr_units); n_err++; end n_cmp++;
    cyc();
    if (wr_units !== 32'd25) begin $display("FAIL wr_units_byte: got %0d want 25", wr_units); n_err++; end n_cmp++;
    if (wr_ticks !== 32'd4) begin $display("FAIL wr_ticks: got %0d want 4", wr_ticks); n_err++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL wr_busy_end: got %0h want 0", busy); n_err++; end n_cmp++;
    if (q_wr_units !== 32'd3) begin $display("FAIL wr_units_word: got %0d want 3", q_wr_units); n_err++; end n_cmp++;
    $display("test_writes done: bytes=%0d beats=%0d", wr_units, q_wr_units);
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    read = 1; burst = 11'd1;
    cyc();
    read = 0;
    repeat (19) cyc();
    rdv = 1;
    cyc();
    rdv = 0;
    cyc();
    if (q_lat_max !== 4'd15) begin $display("FAIL sat_lat_max4: got %0d want 15", q_lat_max); n_err++; end n_cmp++;
    if (q_lat_sum !== 32'd15) begin $display("FAIL sat_lat_sum4: got %0d want 15", q_lat_sum); n_err++; end n_cmp++;
    if (lat_max !== 16'd20) begin $display("FAIL wide_lat_max: got %0d want 20", lat_max); n_err++; end n_cmp++;
    read = 1; burst = 11'd4;
    cyc();
    read = 0; rdv = 1;
    cyc();
    rdv = 0;
    cyc();
    if (q_busy !== 1'b1) begin $display("FAIL midburst_busy: got %0h want 1", q_busy); n_err++; end n_cmp++;
    #2 rst = 1;
    #1;
    if (q_busy !== 1'b0) begin $display("FAIL async_rst_busy: got %0h want 0", q_busy); n_err++; end n_cmp++;
    if (q_lat_min !== 4'hF) begin $display("FAIL async_rst_min: got %0h want f", q_lat_min); n_err++; end n_cmp++;
    if (q_lat_max !== 4'd0) begin $display("FAIL async_rst_max: got %0d want 0", q_lat_max); n_err++; end n_cmp++;
    if (q_rd_words !== 32'd0) begin $display("FAIL async_rst_words: got %0d want 0", q_rd_words); n_err++; end n_cmp++;
    if (lat_max !== 16'd0) begin $display("FAIL async_rst_max16: got %0d want 0", lat_max); n_err++; end n_cmp++;
    cyc();
    rst = 0;
    rdv = 1;
    cyc();
    rdv = 0;
    if (q_orph !== 1'b1) begin $display("FAIL post_rst_orphan: got %0h want 1", q_orph); n_err++; end n_cmp++;
    if (q_rd_words !== 32'd1) begin $display("FAIL post_rst_words: got %0d want 1", q_rd_words); n_err++; end n_cmp++;
    $display("test_saturation_and_reset done");
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_overflow();
    test_orphan();
    test_writes();
    test_saturation_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
